// File: rtl/bram_ctrl.sv
// ============================================================================
// Module   : bram_ctrl
// Brief    : Single-word bus front end for a block RAM with registered reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_ctrl #(
    parameter int          bram_depth = 10,
    parameter logic [31:0] bram_base  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_error,
    output logic                  bram_wen,
    output logic [bram_depth-1:0] bram_waddr,
    output logic [bram_depth-1:0] bram_raddr,
    output logic [31:0]           bram_wdata,
    output logic [3:0]            bram_wstrb,
    input  logic [31:0]           bram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_RDW  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [bram_depth-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;

    logic [31:0]           off;
    logic                  in_range;

    // Offset wraps, so addresses below the base land far out of range.
    assign off      = mem_addr - bram_base;
    assign in_range = (off >> (bram_depth + 2)) == 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    idx_d   = off[bram_depth+1:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (!in_range) begin
                        state_d = S_ERR;
                    end else if (mem_instr && (mem_wstrb != 4'd0)) begin
                        state_d = S_ERR;
                    end else if (mem_wstrb != 4'd0) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR:    state_d = S_IDLE;
            S_RD:    state_d = S_RDW;
            S_RDW:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are gated by reset so an in-flight op is squashed at once.
    always_comb begin
        mem_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = 32'd0;
        bram_wen  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_WR: begin
                    mem_ready = 1'b1;
                    bram_wen  = 1'b1;
                end
                S_RDW: begin
                    mem_ready = 1'b1;
                    mem_rdata = bram_rdata;
                end
                S_ERR: begin
                    mem_ready = 1'b1;
                    mem_error = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bram_waddr = idx_q;
    assign bram_raddr = idx_q;
    assign bram_wdata = wdata_q;
    assign bram_wstrb = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_ctrl.sv
// ============================================================================
// Module   : tb_bram_ctrl
// Brief    : Scoreboard bench for bram_ctrl with a behavioural registered BRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_ctrl;

    localparam int          DEPTH = 10;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 1 << DEPTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_valid, mem_instr;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready, mem_error;
    logic             bram_wen;
    logic [DEPTH-1:0] bram_waddr, bram_raddr;
    logic [31:0]      bram_wdata, bram_rdata;
    logic [3:0]       bram_wstrb;

    bram_ctrl #(.bram_depth(DEPTH), .bram_base(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_error  (mem_error),
        .bram_wen   (bram_wen),
        .bram_waddr (bram_waddr),
        .bram_raddr (bram_raddr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: byte-enabled write, one-cycle registered read.
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (bram_wen) begin
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) ram[bram_waddr][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
        bram_rdata <= ram[bram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      rdata;
        logic             err;
        logic             wr;
        logic [DEPTH-1:0] idx;
        int               at;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [WORDS];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mem_ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'(mem_ready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdata",   mem_rdata, e.rdata);
                check("error",   32'(mem_error), 32'(e.err));
                check("latency", cyc, e.at);
                check("wen",     32'(bram_wen), 32'(e.wr));
                if (e.wr) check("waddr", 32'(bram_waddr), 32'(e.idx));
            end
        end else if (!reset) begin
            check("rdata_idle", mem_rdata, 32'd0);
            check("wen_idle",   32'(bram_wen), 32'd0);
            check("err_idle",   32'(mem_error), 32'd0);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    // Called #1 after a rising edge; the request is accepted at the next edge.
    task automatic req(input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t        e;
        logic [31:0] off;
        logic        rd;
        off     = addr - BASE;
        e.idx   = off[DEPTH+1:2];
        e.err   = (off >= 32'(4 * WORDS)) || (instr && wstrb != 4'd0);
        rd      = !e.err && (wstrb == 4'd0);
        e.wr    = !e.err && (wstrb != 4'd0);
        e.rdata = rd ? shadow[e.idx] : 32'd0;
        e.at    = cyc + (rd ? 2 : 1);
        if (e.wr)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) shadow[e.idx][8*b +: 8] = wdata[8*b +: 8];
        sb.push_back(e);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        wait_drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   d;
        for (int i = 0; i < WORDS; i++) begin
            ram[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        reset     = 1'b1;
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = BASE + 32'h10;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;

        // Reset state, with a request strobe that must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_wen",   32'(bram_wen), 32'd0);
        check("rst_waddr", 32'(bram_waddr), 32'd0);
        check("rst_wdata", bram_wdata, 32'd0);
        check("rst_wstrb", 32'(bram_wstrb), 32'd0);
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write / read, address low bits ignored.
        req(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        req(1'b0, BASE + 32'h10, 32'd0, 4'h0);
        req(1'b0, BASE + 32'h13, 32'd0, 4'h0);

        // Byte strobes.
        req(1'b0, BASE + 32'h08, 32'h1122_3344, 4'hF);
        req(1'b0, BASE + 32'h08, 32'hAABB_CCDD, 4'b0101);
        req(1'b0, BASE + 32'h08, 32'd0, 4'h0);
        check("strobe_merge", shadow[2], 32'h11BB_33DD);

        // Range and fetch-write errors.
        req(1'b0, BASE + 32'h1000, 32'd0, 4'h0);
        req(1'b0, BASE + 32'h1000, 32'h5555_5555, 4'hF);
        req(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0);
        req(1'b1, BASE, 32'hFFFF_FFFF, 4'hF);
        req(1'b0, BASE, 32'd0, 4'h0);
        req(1'b1, BASE + 32'h10, 32'd0, 4'h0);

        // Top word of the window.
        req(1'b0, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF);
        req(1'b0, BASE + 32'hFFC, 32'd0, 4'h0);

        // Continuous strobe: one read every three cycles, nothing queued.
        req(1'b0, BASE + 32'h20, 32'h0BAD_CAFE, 4'hF);
        d = cyc;
        for (int k = 0; k < 3; k++) begin
            e.rdata = 32'h0BAD_CAFE;
            e.err   = 1'b0;
            e.wr    = 1'b0;
            e.idx   = 10'd8;
            e.at    = d + 2 + 3 * k;
            sb.push_back(e);
        end
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = BASE + 32'h20;
        mem_wstrb = 4'h0;
        repeat (9) @(posedge clk);
        #1;
        mem_valid = 1'b0;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;

        // Reset during the write cycle drops the write.
        req(1'b0, BASE + 32'h40, 32'h1234_5678, 4'hF);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h40;
        mem_wdata = 32'hFFFF_0000;
        mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(mem_ready), 32'd0);
        check("midrst_wen",   32'(bram_wen), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_idx", 32'(bram_waddr), 32'd0);
        @(posedge clk);
        #1;
        req(1'b0, BASE + 32'h40, 32'd0, 4'h0);
        check("midrst_mem", ram[16], 32'h1234_5678);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
